bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) feeding the numdisplay
//   7-seg decoder. Accepts one unsigned binary value per handshake and produces N_DIG decimal digits.

---
 rtl/bin2bcd_seq_pkg.sv | 16 +
 rtl/bin2bcd_seq_if.sv | 26 ++
 rtl/bin2bcd_seq_bcd_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter
// that feeds the numdisplay 7-segment decoder.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [31:0] BLANK_DIGIT = 32'h0000_000F;
  localparam int unsigned MAX_DEC     = 99_999_999;
  localparam int          BCD_DIGITS  = 10;
  localparam int          BCD_W       = 4 * BCD_DIGITS;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake and display bus between a value producer (master) and the
// binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
  parameter int IN_W = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] bin_in;
  logic            out_valid;
  logic            ovf;
  logic [31:0]     dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;

  modport master (
    output in_valid, bin_in,
    input  in_ready, out_valid, ovf,
    input  dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, out_valid, ovf,
    output dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7
  );

endinterface

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one binary value per handshake,
// eight zero-extended BCD digits (blanked/saturated) for numdisplay.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int N_DIG    = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(IN_W + 1);

  state_t            state, state_nxt;
  logic [IN_W-1:0]   bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_iter;

  logic              ovf_c;
  logic              lead;
  logic [31:0]       disp  [N_DIG];
  logic [31:0]       dig_q [N_DIG];
  logic              out_valid_q;
  logic              ovf_q;

  for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (bcd_q[4*k +: 4]),
      .adj (adj[4*k +: 4])
    );
  end

  assign last_iter = (cnt_q == CNT_W'(IN_W - 1));

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_iter)    state_nxt = DONE;
      DONE:                      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The adjusted accumulator and the binary MSB shift left together as one word.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          bin_q <= bus.bin_in;
          bcd_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          bcd_q <= BCD_W'({adj, bin_q[IN_W-1]});
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturate on digits 8/9; otherwise blank leading zeros from the top, never dig0.
  always_comb begin
    ovf_c = |bcd_q[BCD_W-1:4*N_DIG];
    lead  = (BLANK_LZ != 0);
    for (int k = N_DIG - 1; k >= 0; k--) begin
      disp[k] = {28'h0, bcd_q[4*k +: 4]};
      if (ovf_c) begin
        disp[k] = 32'd9;
      end else if (lead && (k != 0) && (bcd_q[4*k +: 4] == 4'd0)) begin
        disp[k] = BLANK_DIGIT;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // NOTE: the digit register array is reset explicitly so the display comes up blank, not random.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < N_DIG; k++) dig_q[k] <= BLANK_DIGIT;
    end else begin
      out_valid_q <= (state == DONE);
      if (state == DONE) begin
        ovf_q <= ovf_c;
        dig_q <= disp;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.dig0      = dig_q[0];
  assign bus.dig1      = dig_q[1];
  assign bus.dig2      = dig_q[2];
  assign bus.dig3      = dig_q[3];
  assign bus.dig4      = dig_q[4];
  assign bus.dig5      = dig_q[5];
  assign bus.dig6      = dig_q[6];
  assign bus.dig7      = dig_q[7];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq; expected digits are written as
// eight nibbles, most significant first, with F meaning a blanked digit.
module tb_bin2bcd_seq;
  import bin2bcd_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  bin2bcd_seq_if #(.IN_W(32)) bus ();

  bin2bcd_seq #(
    .IN_W     (32),
    .N_DIG    (8),
    .BLANK_LZ (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input logic [31:0] nib, input logic ovf);
    check({tag, ".dig0"}, bus.dig0, {28'h0, nib[3:0]});
    check({tag, ".dig1"}, bus.dig1, {28'h0, nib[7:4]});
    check({tag, ".dig2"}, bus.dig2, {28'h0, nib[11:8]});
    check({tag, ".dig3"}, bus.dig3, {28'h0, nib[15:12]});
    check({tag, ".dig4"}, bus.dig4, {28'h0, nib[19:16]});
    check({tag, ".dig5"}, bus.dig5, {28'h0, nib[23:20]});
    check({tag, ".dig6"}, bus.dig6, {28'h0, nib[27:24]});
    check({tag, ".dig7"}, bus.dig7, {28'h0, nib[31:28]});
    check({tag, ".ovf"},  bus.ovf,  ovf);
  endtask

  // Called at the negedge after the accept edge; counts cycles until out_valid.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] v,
                         input logic [31:0] nib, input logic ovf);
    int cyc;
    @(negedge clk);
    check({tag, ".ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".busy"}, bus.in_ready, 1'b0);
    wait_out(cyc);
    check({tag, ".latency"}, cyc, 33);
    check_out(tag, nib, ovf);
    @(negedge clk);
    check({tag, ".pulse"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int seen;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.ready", bus.in_ready, 1'b1);
    check("rst.valid", bus.out_valid, 1'b0);
    check_out("rst", 32'hFFFF_FFFF, 1'b0);

    convert("v12345678", 32'd12345678,  32'h1234_5678, 1'b0);
    convert("v0",        32'd0,         32'hFFFF_FFF0, 1'b0);
    convert("v1005",     32'd1005,      32'hFFFF_1005, 1'b0);
    convert("v10",       32'd10,        32'hFFFF_FF10, 1'b0);
    convert("v50000000", 32'd50000000,  32'h5000_0000, 1'b0);
    convert("vmax",      MAX_DEC,       32'h9999_9999, 1'b0);
    convert("vmax1",     MAX_DEC + 1,   32'h9999_9999, 1'b1);
    convert("vallones",  32'hFFFF_FFFF, 32'h9999_9999, 1'b1);

    // Reset ten cycles into a conversion: nothing emerges, outputs blank.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd87654321;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.valid", bus.out_valid, 1'b0);
    check("abort.ready", bus.in_ready, 1'b1);
    check_out("abort", 32'hFFFF_FFFF, 1'b0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort.nopulse", seen, 0);
    convert("v42", 32'd42, 32'hFFFF_FF42, 1'b0);

    // in_valid held through SHIFT with a different value: ignored until after DONE.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bin_in   = 32'd12345678;
    @(negedge clk);
    bus.bin_in = 32'd555;
    check("hold.busy", bus.in_ready, 1'b0);
    wait_out(cyc);
    check("hold.latency", cyc, 33);
    check_out("hold.first", 32'h1234_5678, 1'b0);
    check("hold.idle", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("hold.b2b_accept", bus.in_ready, 1'b0);
    wait_out(cyc);
    check("hold.latency2", cyc, 33);
    check_out("hold.second", 32'hFFFF_F555, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
